// File: rtl/dmac_ioregister_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmac_ioregister_arbiter
//  Purpose  : Two-master round-robin burst arbiter in front of the single
//             bus-side burst port of the DMAC I/O register block. A grant is
//             taken per burst command and held until the final data beat,
//             which is located by an internal beat counter. rlast towards
//             the masters comes from that counter. A master wlast that
//             disagrees with the counter raises a sticky error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module dmac_ioregister_arbiter #(
  parameter int W_D     = 32,
  parameter int W_EXT_A = 32,
  parameter int W_BLEN  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  // master 0
  input  logic                 m0_awvalid,
  input  logic [W_EXT_A-1:0]   m0_awaddr,
  input  logic [W_BLEN-1:0]    m0_awlen,
  output logic                 m0_awready,
  input  logic                 m0_wvalid,
  input  logic [W_D-1:0]       m0_wdata,
  input  logic [W_D/8-1:0]     m0_wstrb,
  input  logic                 m0_wlast,
  output logic                 m0_wready,
  input  logic                 m0_arvalid,
  input  logic [W_EXT_A-1:0]   m0_araddr,
  input  logic [W_BLEN-1:0]    m0_arlen,
  output logic                 m0_arready,
  output logic                 m0_rvalid,
  output logic [W_D-1:0]       m0_rdata,
  output logic                 m0_rlast,
  input  logic                 m0_rready,
  // master 1
  input  logic                 m1_awvalid,
  input  logic [W_EXT_A-1:0]   m1_awaddr,
  input  logic [W_BLEN-1:0]    m1_awlen,
  output logic                 m1_awready,
  input  logic                 m1_wvalid,
  input  logic [W_D-1:0]       m1_wdata,
  input  logic [W_D/8-1:0]     m1_wstrb,
  input  logic                 m1_wlast,
  output logic                 m1_wready,
  input  logic                 m1_arvalid,
  input  logic [W_EXT_A-1:0]   m1_araddr,
  input  logic [W_BLEN-1:0]    m1_arlen,
  output logic                 m1_arready,
  output logic                 m1_rvalid,
  output logic [W_D-1:0]       m1_rdata,
  output logic                 m1_rlast,
  input  logic                 m1_rready,
  // shared bus-side port
  output logic                 io_awvalid,
  output logic [W_EXT_A-1:0]   io_awaddr,
  output logic [W_BLEN-1:0]    io_awlen,
  input  logic                 io_awready,
  output logic                 io_wvalid,
  output logic [W_D-1:0]       io_wdata,
  output logic [W_D/8-1:0]     io_wstrb,
  output logic                 io_wlast,
  input  logic                 io_wready,
  output logic                 io_arvalid,
  output logic [W_EXT_A-1:0]   io_araddr,
  output logic [W_BLEN-1:0]    io_arlen,
  input  logic                 io_arready,
  input  logic                 io_rvalid,
  input  logic [W_D-1:0]       io_rdata,
  input  logic                 io_rlast,
  output logic                 io_rready,
  // status
  output logic                 err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_RADDR = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  localparam logic [W_BLEN:0] CNT_ONE = {{W_BLEN{1'b0}}, 1'b1};

  logic [2:0]      state_q,   state_d;
  logic            grant_m_q, grant_m_d;   // granted master index
  logic            rr_q,      rr_d;        // master that has priority next
  logic [W_BLEN:0] cnt_q,     cnt_d;       // beats still to transfer
  logic            err_q,     err_d;

  // Granted-master view of every master-side channel
  logic               w_awvalid;
  logic [W_EXT_A-1:0] w_awaddr;
  logic [W_BLEN-1:0]  w_awlen;
  logic               w_wvalid;
  logic [W_D-1:0]     w_wdata;
  logic [W_D/8-1:0]   w_wstrb;
  logic               w_wlast;
  logic               w_arvalid;
  logic [W_EXT_A-1:0] w_araddr;
  logic [W_BLEN-1:0]  w_arlen;
  logic               w_rready;

  logic w_req0, w_req1, w_pick, w_pick_aw;
  logic w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
  logic w_last_beat;

  // The bus returns its own rlast, but the burst end is taken from the counter
  logic w_unused_io_rlast;
  assign w_unused_io_rlast = io_rlast;

  // Channel muxes driven purely by the registered grant
  assign w_awvalid = grant_m_q ? m1_awvalid : m0_awvalid;
  assign w_awaddr  = grant_m_q ? m1_awaddr  : m0_awaddr;
  assign w_awlen   = grant_m_q ? m1_awlen   : m0_awlen;
  assign w_wvalid  = grant_m_q ? m1_wvalid  : m0_wvalid;
  assign w_wdata   = grant_m_q ? m1_wdata   : m0_wdata;
  assign w_wstrb   = grant_m_q ? m1_wstrb   : m0_wstrb;
  assign w_wlast   = grant_m_q ? m1_wlast   : m0_wlast;
  assign w_arvalid = grant_m_q ? m1_arvalid : m0_arvalid;
  assign w_araddr  = grant_m_q ? m1_araddr  : m0_araddr;
  assign w_arlen   = grant_m_q ? m1_arlen   : m0_arlen;
  assign w_rready  = grant_m_q ? m1_rready  : m0_rready;

  // Arbitration: the rr master wins if it asks, otherwise the other one;
  // inside the winner a write command beats a read command.
  assign w_req0    = m0_awvalid | m0_arvalid;
  assign w_req1    = m1_awvalid | m1_arvalid;
  assign w_pick    = rr_q ? w_req1 : ~w_req0;
  assign w_pick_aw = w_pick ? m1_awvalid : m0_awvalid;

  // Handshakes on the shared port, qualified by state
  assign w_aw_hs     = (state_q == S_WADDR) && w_awvalid && io_awready;
  assign w_ar_hs     = (state_q == S_RADDR) && w_arvalid && io_arready;
  assign w_w_hs      = (state_q == S_WDATA) && w_wvalid  && io_wready;
  assign w_r_hs      = (state_q == S_RDATA) && io_rvalid && w_rready;
  assign w_last_beat = (cnt_q == CNT_ONE);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, round-robin pointer, beat counter and sticky error registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_m_q <= 1'b0;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      grant_m_q <= grant_m_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d   = state_q;
    grant_m_d = grant_m_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (w_req0 || w_req1) begin
          grant_m_d = w_pick;
          state_d   = w_pick_aw ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        if (w_aw_hs) begin
          cnt_d   = {1'b0, w_awlen} + CNT_ONE;
          state_d = S_WDATA;
        end
      end
      S_RADDR: begin
        if (w_ar_hs) begin
          cnt_d   = {1'b0, w_arlen} + CNT_ONE;
          state_d = S_RDATA;
        end
      end
      S_WDATA: begin
        if (w_w_hs) begin
          cnt_d = cnt_q - CNT_ONE;
          // Burst length is owned by the counter; wlast is only cross-checked
          if (w_wlast != w_last_beat) begin
            err_d = 1'b1;
          end
          if (w_last_beat) begin
            state_d = S_IDLE;
            rr_d    = ~grant_m_q;
          end
        end
      end
      S_RDATA: begin
        if (w_r_hs) begin
          cnt_d = cnt_q - CNT_ONE;
          if (w_last_beat) begin
            state_d = S_IDLE;
            rr_d    = ~grant_m_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: shared port from the granted master, handshakes back to it only
  always_comb begin
    io_awvalid = (state_q == S_WADDR) && w_awvalid;
    io_awaddr  = w_awaddr;
    io_awlen   = w_awlen;
    io_arvalid = (state_q == S_RADDR) && w_arvalid;
    io_araddr  = w_araddr;
    io_arlen   = w_arlen;
    io_wvalid  = (state_q == S_WDATA) && w_wvalid;
    io_wdata   = w_wdata;
    io_wstrb   = w_wstrb;
    io_wlast   = w_wlast;
    io_rready  = (state_q == S_RDATA) && w_rready;

    m0_awready = (state_q == S_WADDR) && !grant_m_q && io_awready;
    m1_awready = (state_q == S_WADDR) &&  grant_m_q && io_awready;
    m0_arready = (state_q == S_RADDR) && !grant_m_q && io_arready;
    m1_arready = (state_q == S_RADDR) &&  grant_m_q && io_arready;
    m0_wready  = (state_q == S_WDATA) && !grant_m_q && io_wready;
    m1_wready  = (state_q == S_WDATA) &&  grant_m_q && io_wready;
    m0_rvalid  = (state_q == S_RDATA) && !grant_m_q && io_rvalid;
    m1_rvalid  = (state_q == S_RDATA) &&  grant_m_q && io_rvalid;
    m0_rlast   = (state_q == S_RDATA) && !grant_m_q && w_last_beat;
    m1_rlast   = (state_q == S_RDATA) &&  grant_m_q && w_last_beat;
    m0_rdata   = io_rdata;
    m1_rdata   = io_rdata;

    err        = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmac_ioregister_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmac_ioregister_arbiter
//  Purpose  : Scoreboard bench for dmac_ioregister_arbiter. Address grants,
//             write beats and read beats are queued as expectations when the
//             masters are driven and compared when they appear on the bus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmac_ioregister_arbiter;

  localparam int W_D     = 32;
  localparam int W_EXT_A = 32;
  localparam int W_BLEN  = 8;
  localparam int TMO     = 100;
  localparam logic [31:0] RD_BASE = 32'hA500_0000;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic m0_awvalid, m0_awready, m0_wvalid, m0_wlast, m0_wready, m0_arvalid, m0_arready;
  logic m0_rvalid, m0_rlast, m0_rready;
  logic [31:0] m0_awaddr, m0_araddr, m0_wdata, m0_rdata;
  logic [7:0]  m0_awlen, m0_arlen;
  logic [3:0]  m0_wstrb;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_arvalid, m1_arready;
  logic m1_rvalid, m1_rlast, m1_rready;
  logic [31:0] m1_awaddr, m1_araddr, m1_wdata, m1_rdata;
  logic [7:0]  m1_awlen, m1_arlen;
  logic [3:0]  m1_wstrb;
  logic io_awvalid, io_awready, io_wvalid, io_wlast, io_wready, io_arvalid, io_arready;
  logic io_rvalid, io_rlast, io_rready, err;
  logic [31:0] io_awaddr, io_araddr, io_wdata, io_rdata;
  logic [7:0]  io_awlen, io_arlen;
  logic [3:0]  io_wstrb;

  dmac_ioregister_arbiter #(.W_D(W_D), .W_EXT_A(W_EXT_A), .W_BLEN(W_BLEN)) dut (
    .CLK(CLK), .RST(RST),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awready(m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
    .m0_wready(m0_wready), .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
    .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
    .m0_rready(m0_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wready(m1_wready), .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
    .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
    .m1_rready(m1_rready),
    .io_awvalid(io_awvalid), .io_awaddr(io_awaddr), .io_awlen(io_awlen), .io_awready(io_awready),
    .io_wvalid(io_wvalid), .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_wlast(io_wlast),
    .io_wready(io_wready), .io_arvalid(io_arvalid), .io_araddr(io_araddr), .io_arlen(io_arlen),
    .io_arready(io_arready), .io_rvalid(io_rvalid), .io_rdata(io_rdata), .io_rlast(io_rlast),
    .io_rready(io_rready), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] addr_q[$];
  logic [63:0] wr_q[$];
  logic [63:0] rd_q[$];
  logic [31:0] rd_exp = RD_BASE;
  bit chk_m1_idle = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- shared-port slave: awready/arready one cycle late ----------------
  bit aw_seen, ar_seen, r_hs;
  initial begin
    io_awready = 0; io_arready = 0; io_wready = 1; io_rvalid = 1;
    io_rdata = RD_BASE; io_rlast = 1; aw_seen = 0; ar_seen = 0;
    forever begin
      @(negedge CLK);
      r_hs = io_rvalid && io_rready && !RST;
      @(posedge CLK); #2;
      if (r_hs) io_rdata = io_rdata + 32'd1;
      if (io_awvalid && !io_awready) begin
        if (aw_seen) io_awready = 1; else aw_seen = 1;
      end else begin
        io_awready = 0; aw_seen = 0;
      end
      if (io_arvalid && !io_arready) begin
        if (ar_seen) io_arready = 1; else ar_seen = 1;
      end else begin
        io_arready = 0; ar_seen = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      if (io_awvalid && io_awready) begin
        if (addr_q.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("aw_grant", {21'd0, 1'b1, m1_awready, m0_awready, io_awaddr, io_awlen}, addr_q.pop_front());
      end
      if (io_arvalid && io_arready) begin
        if (addr_q.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("ar_grant", {21'd0, 1'b0, m1_arready, m0_arready, io_araddr, io_arlen}, addr_q.pop_front());
      end
      if (io_wvalid && io_wready) begin
        if (wr_q.size() == 0) chk("w_unexpected", 1, 0);
        else chk("w_beat", {25'd0, m1_wready, m0_wready, io_wdata, io_wstrb, io_wlast}, wr_q.pop_front());
      end
      if (m0_rvalid || m1_rvalid)
        chk("rready_mirror", io_rready, m1_rvalid ? m1_rready : m0_rready);
      if (io_rvalid && io_rready) begin
        if (rd_q.size() == 0) chk("r_unexpected", 1, 0);
        else chk("r_beat", {28'd0, m1_rvalid, m0_rvalid, (m1_rvalid ? m1_rdata : m0_rdata), m1_rlast, m0_rlast},
                 rd_q.pop_front());
      end
      if (chk_m1_idle)
        chk("m1_idle", {m1_awready, m1_wready, m1_arready, m1_rvalid}, 0);
    end
  end

  // ---------------- master drive helpers ----------------
  task automatic drv_aw(input int m, input logic v, input logic [31:0] a, input logic [7:0] l);
    if (m == 0) begin m0_awvalid = v; m0_awaddr = a; m0_awlen = l; end
    else        begin m1_awvalid = v; m1_awaddr = a; m1_awlen = l; end
  endtask

  task automatic drv_ar(input int m, input logic v, input logic [31:0] a, input logic [7:0] l);
    if (m == 0) begin m0_arvalid = v; m0_araddr = a; m0_arlen = l; end
    else        begin m1_arvalid = v; m1_araddr = a; m1_arlen = l; end
  endtask

  task automatic drv_w(input int m, input logic v, input logic [31:0] d, input logic [3:0] s, input logic l);
    if (m == 0) begin m0_wvalid = v; m0_wdata = d; m0_wstrb = s; m0_wlast = l; end
    else        begin m1_wvalid = v; m1_wdata = d; m1_wstrb = s; m1_wlast = l; end
  endtask

  task automatic drv_rr(input int m, input logic v);
    if (m == 0) m0_rready = v; else m1_rready = v;
  endtask

  function automatic logic sig(input int m, input int ch);
    case (ch)
      0:       return (m == 0) ? m0_awready : m1_awready;
      1:       return (m == 0) ? m0_wready  : m1_wready;
      2:       return (m == 0) ? m0_arready : m1_arready;
      default: return (m == 0) ? (m0_rvalid && m0_rready) : (m1_rvalid && m1_rready);
    endcase
  endfunction

  function automatic void push_addr(input logic dir, input int m, input logic [31:0] a, input logic [7:0] l);
    addr_q.push_back({21'd0, dir, (m == 1), (m == 0), a, l});
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the handshake edge
  task automatic wait_hs(input int m, input int ch, input string tag);
    int t = 0;
    @(negedge CLK);
    while (!sig(m, ch) && t < TMO) begin
      @(negedge CLK);
      t++;
    end
    if (!sig(m, ch)) chk({tag, "_timeout"}, 0, 1);
    @(posedge CLK); #1;
  endtask

  // Write burst; bad_idx < 0 gives a correct wlast, else wlast sits on that beat
  task automatic mwrite(input int m, input logic [31:0] a, input logic [7:0] l, input int bad_idx);
    logic [31:0] d;
    logic [3:0]  s;
    logic        lst;
    drv_aw(m, 1, a, l);
    wait_hs(m, 0, "aw");
    drv_aw(m, 0, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      d   = {a[23:0], 8'(i)};
      s   = 4'hF ^ 4'(i);
      lst = (bad_idx < 0) ? (i == int'(l)) : (i == bad_idx);
      drv_w(m, 1, d, s, lst);
      wr_q.push_back({25'd0, (m == 1), (m == 0), d, s, lst});
      wait_hs(m, 1, "w");
    end
    drv_w(m, 0, 32'd0, 4'd0, 1'b0);
  endtask

  // Read burst; toggle makes rready go 1,0,1,... during the data phase
  task automatic mread(input int m, input logic [31:0] a, input logic [7:0] l, input bit toggle);
    bit ph, got;
    int t;
    drv_ar(m, 1, a, l);
    wait_hs(m, 2, "ar");
    drv_ar(m, 0, a, l);
    ph = 1;
    for (int i = 0; i <= int'(l); i++) begin
      rd_q.push_back({28'd0, (m == 1), (m == 0), rd_exp,
                      (i == int'(l)) && (m == 1), (i == int'(l)) && (m == 0)});
      rd_exp = rd_exp + 32'd1;
      got = 0; t = 0;
      while (!got && t < TMO) begin
        drv_rr(m, toggle ? ph : 1'b1);
        ph = ~ph;
        @(negedge CLK);
        got = sig(m, 3);
        @(posedge CLK); #1;
        t++;
      end
      if (!got) chk("r_timeout", 0, 1);
    end
    drv_rr(m, 0);
  endtask

  task automatic chk_all_idle(input string tag);
    chk(tag, {io_awvalid, io_wvalid, io_arvalid, io_rready,
              m0_awready, m0_wready, m0_arready, m0_rvalid,
              m1_awready, m1_wready, m1_arready, m1_rvalid}, 0);
  endtask

  task automatic do_reset();
    RST = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    RST = 1;
    drv_aw(0, 0, 0, 0); drv_aw(1, 0, 0, 0);
    drv_ar(0, 0, 0, 0); drv_ar(1, 0, 0, 0);
    drv_w(0, 0, 0, 0, 0); drv_w(1, 0, 0, 0, 0);
    drv_rr(0, 0); drv_rr(1, 0);
    do_reset();
    @(negedge CLK);
    chk_all_idle("reset_outputs");
    chk("reset_err", err, 0);
    @(posedge CLK); #1;

    // 1: M0 write 0x40 len 3, one cycle of arbitration latency, M1 untouched
    chk_m1_idle = 1;
    push_addr(1, 0, 32'h40, 8'd3);
    drv_aw(0, 1, 32'h40, 8'd3);
    @(negedge CLK); chk("lat_idle", io_awvalid, 0);
    @(posedge CLK); #1;
    @(negedge CLK); chk("lat_waddr", io_awvalid, 1);
    @(posedge CLK); #1;
    mwrite(0, 32'h40, 8'd3, -1);
    @(negedge CLK);
    chk_all_idle("t1_back_idle");
    chk_m1_idle = 0;
    @(posedge CLK); #1;

    // rr now points at M1: simultaneous requests must serve M1 first
    push_addr(0, 1, 32'h300, 8'd0);
    push_addr(1, 0, 32'h310, 8'd0);
    fork
      mwrite(0, 32'h310, 8'd0, -1);
      mread(1, 32'h300, 8'd0, 0);
    join

    // 2: after reset rr=0 -> M0 write first, then M1 read len 1
    do_reset();
    push_addr(1, 0, 32'h100, 8'd1);
    push_addr(0, 1, 32'h200, 8'd1);
    fork
      mwrite(0, 32'h100, 8'd1, -1);
      mread(1, 32'h200, 8'd1, 0);
    join

    // 3: M0 keeps writing while M1 keeps reading -> strict alternation
    push_addr(1, 0, 32'h500, 8'd0);
    push_addr(0, 1, 32'h600, 8'd0);
    push_addr(1, 0, 32'h504, 8'd0);
    push_addr(0, 1, 32'h604, 8'd0);
    push_addr(1, 0, 32'h508, 8'd0);
    fork
      begin
        mwrite(0, 32'h500, 8'd0, -1);
        mwrite(0, 32'h504, 8'd0, -1);
        mwrite(0, 32'h508, 8'd0, -1);
      end
      begin
        mread(1, 32'h600, 8'd0, 0);
        mread(1, 32'h604, 8'd0, 0);
      end
    join

    // 4: M1 read len 7 with rready toggling
    push_addr(0, 1, 32'h700, 8'd7);
    mread(1, 32'h700, 8'd7, 1);
    @(negedge CLK);
    chk("err_still_clear", err, 0);
    @(posedge CLK); #1;

    // 5: M0 write len 2 with wlast on beat 2 -> ends on count, err sticks
    push_addr(1, 0, 32'h800, 8'd2);
    mwrite(0, 32'h800, 8'd2, 1);
    @(negedge CLK);
    chk("err_set", err, 1);
    chk_all_idle("t5_ended_on_count");
    @(posedge CLK); #1;
    push_addr(0, 1, 32'h900, 8'd0);
    mread(1, 32'h900, 8'd0, 0);
    push_addr(1, 0, 32'h904, 8'd0);
    mwrite(0, 32'h904, 8'd0, -1);
    @(negedge CLK);
    chk("err_sticky", err, 1);
    @(posedge CLK); #1;

    // 6: reset during beat 2 of a 4-beat M0 write (rr was 1 before)
    push_addr(1, 0, 32'hA00, 8'd3);
    drv_aw(0, 1, 32'hA00, 8'd3);
    wait_hs(0, 0, "aw_rst");
    drv_aw(0, 0, 32'hA00, 8'd3);
    drv_w(0, 1, 32'hD000_0000, 4'hF, 0);
    wr_q.push_back({25'd0, 1'b0, 1'b1, 32'hD000_0000, 4'hF, 1'b0});
    wait_hs(0, 1, "w_rst");
    drv_w(0, 1, 32'hD000_0001, 4'hE, 0);
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    drv_w(0, 0, 32'd0, 4'd0, 0);
    @(negedge CLK);
    chk_all_idle("midburst_reset_outputs");
    chk("midburst_reset_err", err, 0);
    @(posedge CLK); #1;
    // rr must be back at M0
    push_addr(1, 0, 32'hB00, 8'd0);
    push_addr(0, 1, 32'hC00, 8'd0);
    fork
      mwrite(0, 32'hB00, 8'd0, -1);
      mread(1, 32'hC00, 8'd0, 0);
    join
    // lone M1 request is granted after exactly one cycle
    push_addr(0, 1, 32'hC40, 8'd1);
    drv_ar(1, 1, 32'hC40, 8'd1);
    @(negedge CLK); chk("m1_lat_idle", io_arvalid, 0);
    @(posedge CLK); #1;
    @(negedge CLK); chk("m1_lat_raddr", io_arvalid, 1);
    @(posedge CLK); #1;
    mread(1, 32'hC40, 8'd1, 0);

    repeat (3) @(posedge CLK);
    #1;
    chk("addr_q_drained", 64'(addr_q.size()), 0);
    chk("wr_q_drained", 64'(wr_q.size()), 0);
    chk("rd_q_drained", 64'(rd_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmac_ioregister_arbiter.md
Name: dmac_ioregister_arbiter

Overview:
Two-master burst arbiter that shares the single bus-side burst port of the DMAC I/O register block between two requesters, for example a host DMA engine and a debug or config master.
It arbitrates per burst command using round-robin and holds the grant until the last data beat completes.
It muxes the address, write-data and read-data channels of the granted master onto the shared port.
It generates `rlast` itself from a beat counter and flags `wlast` mismatches.

Parameters:
W_D, 32, data width in bits, power of 2
W_EXT_A, 32, byte address width
W_BLEN, 8, burst length field width; beats per burst = len+1

Ports:
CLK  in  1  single clock for the whole block
RST  in  1  synchronous, active-high reset
mN_awvalid/mN_awaddr/mN_awlen  in  1/W_EXT_A/W_BLEN  write command from master N (N=0,1)
mN_awready  out  1  write command accepted
mN_wvalid/mN_wdata/mN_wstrb/mN_wlast  in  1/W_D/W_D/8/1  write data from master N
mN_wready  out  1  write beat accepted
mN_arvalid/mN_araddr/mN_arlen  in  1/W_EXT_A/W_BLEN  read command from master N
mN_arready  out  1  read command accepted
mN_rvalid/mN_rdata/mN_rlast  out  1/W_D/1  read data to master N
mN_rready  in  1  master N accepts read beat
io_awvalid/io_awaddr/io_awlen  out  1/W_EXT_A/W_BLEN  shared write command
io_awready  in  1
io_wvalid/io_wdata/io_wstrb/io_wlast  out  1/W_D/W_D/8/1  shared write data
io_wready  in  1
io_arvalid/io_araddr/io_arlen  out  1/W_EXT_A/W_BLEN  shared read command
io_arready  in  1
io_rvalid/io_rdata/io_rlast  in  1/W_D/1  shared read data; io_rlast is ignored
io_rready  out  1
err  out  1  sticky: a master's wlast disagreed with the arbiter's beat count

Behaviour:
- Reset (RST=1 at a CLK edge; also applies mid-burst):
  - state=IDLE, grant=0, rr=0 (M0 has priority first), cnt=0, err=0.
  - All valid/ready outputs are 0 in IDLE. Any in-flight burst is abandoned with no drain.
- States and transitions:
  - IDLE:
    - Sample the four requests m0_awvalid, m0_arvalid, m1_awvalid, m1_arvalid.
    - Master choice: the master pointed to by rr wins if it requests; otherwise the other master wins.
    - Within the chosen master, aw beats ar.
    - Register grant (master, dir) and go to WADDR or RADDR next cycle. There is exactly 1 cycle of arbitration latency.
    - No request: stay in IDLE.
  - WADDR:
    - io_awvalid=1; io_awaddr and io_awlen are muxed from the granted master.
    - mG_awready=io_awready.
    - On io_awvalid&&io_awready: cnt<=awlen+1 (width W_BLEN+1, no overflow; len=0 gives 1 beat), go to WDATA.
  - RADDR:
    - Same as WADDR on the ar channel; the accepting handshake moves to RDATA.
  - WDATA:
    - io_wvalid, io_wdata, io_wstrb, io_wlast are taken from the granted master.
    - mG_wready=io_wready.
    - Each io_wvalid&&io_wready beat decrements cnt.
    - Beat with cnt==1: go to IDLE and set rr<=~grant_master.
    - Any accepted beat where wlast != (cnt==1) sets err. The burst still ends on count, not on wlast.
  - RDATA:
    - mG_rvalid=io_rvalid, mG_rdata=io_rdata, io_rready=mG_rready.
    - mG_rlast=(cnt==1).
    - Each io_rvalid&&mG_rready beat decrements cnt. The cnt==1 beat goes to IDLE and flips rr.
- Non-granted master: all its ready/valid outputs are 0. Its data outputs are don't-care but driven from the muxed bus.
- Masters must hold valid, addr and len stable until ready. If a master retracts, the arbiter stays in the ADDR state and keeps waiting.
- Channel muxing is combinational from the registered grant and state. There are no extra data-path registers, so throughput is 1 beat/cycle when downstream allows.
- rr flips only on burst completion, never on reset-abandon.
- err clears only on RST.

Test Plan:
- M0 write awaddr=0x40, awlen=3, io_awready after 1 cycle, io_wready=1 -> io_awaddr=0x40, 4 beats forwarded, m1 readies stay 0, return to IDLE, rr=1.
- M0 aw and M1 ar asserted in the same cycle after reset -> M0 write first (rr=0). M1 read (arlen=1) is granted immediately after, with m1_rlast high on the 2nd beat only.
- M0 continuously requests 3 single-beat writes while M1 holds ar -> grant order M0, M1, M0, M1. There is no back-to-back grant to the same master while the other waits.
- M1 read arlen=7 with mN_rready toggling 1,0,1,... -> exactly 8 beats transferred, io_rready mirrors m1_rready, cnt decrements only on handshake.
- M0 write awlen=2 with wlast asserted on beat 2 -> burst ends after beat 3, err=1 and stays 1 until RST.
- RST pulsed during beat 2 of a 4-beat write -> next cycle state=IDLE, all readies 0, rr=0, err=0. A new M1 request is then granted after 1 cycle.
